// File: rtl/fft_frame_tx_if.sv
// Bin-stream input, frame output and analyzer handshake of the FFT frame transmitter.
// Latency: n/a (signal bundle only).
// Backpressure: bin_ready from the block throttles the serial bin source.
interface fft_frame_tx_if;
    logic               bin_valid;
    logic               bin_first;
    logic [15:0]        bin_real;
    logic [15:0]        bin_imag;
    logic               bin_ready;
    logic               fft_valid;
    logic [15:0][31:0]  fft_d;      // fft_d[N] is frame slot N = {real, imag}
    logic               done;
    logic               busy;

    // Bin source / frame consumer side
    modport master (
        output bin_valid, bin_first, bin_real, bin_imag, done,
        input  bin_ready, fft_valid, fft_d, busy
    );

    // Frame transmitter side
    modport slave (
        input  bin_valid, bin_first, bin_real, bin_imag, done,
        output bin_ready, fft_valid, fft_d, busy
    );
endinterface

// File: rtl/fft_frame_tx.sv
// Collects 16 serial FFT bins into ping-pong banks and presents each full frame in parallel.
// Latency: 16th bin accepted at edge k -> fft_valid pulse between edges k+1 and k+2.
// Backpressure: bin_ready drops while the write bank is full; frames wait for done.
module fft_frame_tx #(
    parameter bit BITREV = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    fft_frame_tx_if.slave io
);

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_WAIT = 2'd2
    } tx_state_t;

    tx_state_t   state;
    tx_state_t   state_nxt;
    logic [31:0] mem [2][16];
    logic        wr_bank;
    logic        rd_bank;
    logic [3:0]  cnt;
    logic [1:0]  full;
    logic [1:0]  full_nxt;
    logic [3:0]  slot;
    logic        xfer;
    logic        last_bin;
    logic        ack;

    function automatic logic [3:0] bitrev4(input logic [3:0] k);
        bitrev4 = {k[0], k[1], k[2], k[3]};
    endfunction

    // The writer only ever targets a bank that is not full, so a full bank is never disturbed
    assign io.bin_ready = ~full[wr_bank];
    assign xfer         = io.bin_valid & io.bin_ready;
    assign last_bin     = xfer & ~io.bin_first & (cnt == 4'd15);
    assign ack          = (state == TX_WAIT) & io.done;
    assign io.busy      = |full;

    // Slot for the incoming bin; a frame restart always lands in slot 0
    always_comb begin
        slot = BITREV ? bitrev4(cnt) : cnt;
        if (io.bin_first) begin
            slot = 4'd0;
        end
    end

    // Bank storage: contents carry no reset, only the flags decide validity
    always_ff @(posedge clk) begin
        if (xfer) begin
            mem[wr_bank][slot] <= {io.bin_real, io.bin_imag};
        end
    end

    // Write counter and write-bank pointer; bin_first restarts the frame in the same bank
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= 4'd0;
            wr_bank <= 1'b0;
        end else if (xfer) begin
            if (io.bin_first) begin
                cnt <= 4'd1;
            end else if (last_bin) begin
                cnt     <= 4'd0;
                wr_bank <= ~wr_bank;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    // Full flags: set by the writer and cleared by the reader may hit different banks in one edge
    always_comb begin
        full_nxt = full;
        if (last_bin) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (ack) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    // Full flag and read-bank pointer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full    <= 2'b00;
            rd_bank <= 1'b0;
        end else begin
            full <= full_nxt;
            if (ack) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // Reader state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= TX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Reader next state and the one-cycle frame strobe; done only counts while waiting
    always_comb begin
        state_nxt    = state;
        io.fft_valid = 1'b0;
        case (state)
            TX_IDLE: begin
                if (full[rd_bank]) begin
                    state_nxt = TX_SEND;
                end
            end
            TX_SEND: begin
                io.fft_valid = 1'b1;
                state_nxt    = TX_WAIT;
            end
            TX_WAIT: begin
                if (io.done) begin
                    state_nxt = TX_IDLE;
                end
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    // Frame outputs follow the read bank, which is held until done is accepted
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            io.fft_d[i] = mem[rd_bank][i];
        end
    end

endmodule

// File: tb/tb_fft_frame_tx.sv
// Drives one bin stream into a BITREV=0 and a BITREV=1 instance and checks both against a frame-queue model.
// Latency: checks the 16th-bin-to-fft_valid timing explicitly and frame data every presented cycle.
// Backpressure: model accepts a bin only while fewer than two frames are unacknowledged.
module tb_fft_frame_tx;

    typedef logic [31:0] frame_t [16];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bin_valid = 1'b0;
    logic        bin_first = 1'b0;
    logic [15:0] bin_real = '0;
    logic [15:0] bin_imag = '0;
    logic        done = 1'b0;

    logic              rdy [2];
    logic              vld [2];
    logic              bsy [2];
    logic [15:0][31:0] dq  [2];

    fft_frame_tx_if if0 ();
    fft_frame_tx_if if1 ();

    assign if0.bin_valid = bin_valid;
    assign if0.bin_first = bin_first;
    assign if0.bin_real  = bin_real;
    assign if0.bin_imag  = bin_imag;
    assign if0.done      = done;
    assign if1.bin_valid = bin_valid;
    assign if1.bin_first = bin_first;
    assign if1.bin_real  = bin_real;
    assign if1.bin_imag  = bin_imag;
    assign if1.done      = done;

    assign rdy[0] = if0.bin_ready;
    assign vld[0] = if0.fft_valid;
    assign bsy[0] = if0.busy;
    assign dq[0]  = if0.fft_d;
    assign rdy[1] = if1.bin_ready;
    assign vld[1] = if1.fft_valid;
    assign bsy[1] = if1.busy;
    assign dq[1]  = if1.fft_d;

    fft_frame_tx #(.BITREV(1'b0)) dut0 (.clk(clk), .rst(rst), .io(if0.slave));
    fft_frame_tx #(.BITREV(1'b1)) dut1 (.clk(clk), .rst(rst), .io(if1.slave));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bins of the frame being assembled, and completed frames in arrival order
    logic [31:0] part [$];
    frame_t      frames [$];
    bit          presented = 1'b0;
    int          wait_cnt = 0;
    int          ack_delay = 0;
    int          acks = 0;
    int          disc_presented = 0;
    int          pulses [2] = '{0, 0};

    function automatic logic [3:0] rev4(input logic [3:0] k);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[3 - i] = k[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare presented frame of instance b with the oldest completed frame
    task automatic chk_frame(input int b);
        logic [3:0] s;
        for (int i = 0; i < 16; i++) begin
            s = 4'(i);
            chk($sformatf("fft_d%0d_bitrev%0d", i, b), dq[b][i],
                (b == 1) ? frames[0][rev4(s)] : frames[0][i]);
        end
    endtask

    // One clock cycle, entered and left at a falling edge
    task automatic cycle(input bit v, input bit f, input logic [15:0] re, input logic [15:0] im,
                         input bit dn, output bit acc);
        bit mready;
        bit sv;
        bin_valid = v;
        bin_first = f;
        bin_real  = re;
        bin_imag  = im;
        done      = dn || (presented && ack_delay >= 0 && wait_cnt >= ack_delay);
        #1;
        mready = frames.size() < 2;
        sv     = vld[1];
        for (int b = 0; b < 2; b++) begin
            chk($sformatf("bin_ready%0d", b), 32'(rdy[b]), 32'(mready));
            chk($sformatf("busy%0d", b), 32'(bsy[b]), 32'(frames.size() != 0));
            chk($sformatf("valid_sync%0d", b), 32'(vld[b]), 32'(sv));
            if (presented) begin
                chk($sformatf("valid_one_cycle%0d", b), 32'(vld[b]), 32'd0);
                chk_frame(b);
            end else if (vld[b]) begin
                pulses[b]++;
                chk($sformatf("valid_has_frame%0d", b), 32'(frames.size() != 0), 32'd1);
                if (frames.size() != 0) chk_frame(b);
            end
        end
        acc = v && mready;
        @(posedge clk);
        if (done && presented) begin
            void'(frames.pop_front());
            presented = 1'b0;
            acks++;
        end else if (presented) begin
            wait_cnt++;
        end
        if (sv && !presented) begin
            presented = 1'b1;
            wait_cnt  = 0;
        end
        if (acc) begin
            if (f) part.delete();
            part.push_back({re, im});
            if (part.size() == 16) begin
                frame_t fr;
                for (int i = 0; i < 16; i++) fr[i] = part[i];
                frames.push_back(fr);
                part.delete();
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, acc);
    endtask

    task automatic send_bin(input bit f, input logic [15:0] re, input logic [15:0] im);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 300) begin
            cycle(1'b1, f, re, im, 1'b0, acc);
            n++;
        end
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_rand(input int n, input bit first_on_first);
        for (int i = 0; i < n; i++) begin
            send_bin(first_on_first && i == 0, 16'($urandom), 16'($urandom));
        end
    endtask

    // Asynchronous reset asserted mid-cycle, released on a falling edge
    task automatic do_reset();
        bin_valid = 1'b0;
        done      = 1'b0;
        #2 rst = 1'b0;
        #1;
        for (int b = 0; b < 2; b++) begin
            chk($sformatf("rst_valid%0d", b), 32'(vld[b]), 32'd0);
            chk($sformatf("rst_busy%0d", b), 32'(bsy[b]), 32'd0);
            chk($sformatf("rst_ready%0d", b), 32'(rdy[b]), 32'd1);
        end
        if (presented) disc_presented++;
        part.delete();
        frames.delete();
        presented = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int p0;
        int n;
        bit acc;

        // Reset state
        @(negedge clk);
        do_reset();

        // done in TX_IDLE is ignored
        cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, acc);

        // Ramp frame real=k imag=-k, latency and slot checks for both orderings
        ack_delay = 14;
        for (int k = 0; k < 16; k++) send_bin(k == 0, 16'(k), 16'(-k));
        chk("lat_edge_k", 32'(vld[1]), 32'd0);
        idle(1);
        chk("lat_edge_k1", 32'(vld[1]), 32'd1);
        chk("ramp_b1_d8", dq[1][8], 32'h0001FFFF);
        chk("ramp_b1_d1", dq[1][1], 32'h0008FFF8);
        chk("ramp_b1_d15", dq[1][15], 32'h000FFFF1);
        chk("ramp_b0_d5", dq[0][5], 32'h0005FFFB);
        chk("ramp_b0_d15", dq[0][15], 32'h000FFFF1);
        // done in the TX_SEND cycle is ignored; frame stays held
        cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, acc);
        idle(20);
        chk("ramp_pulses", 32'(pulses[1]), 32'd1);
        chk("ramp_acked", 32'(acks), 32'd1);

        // Back-to-back frames with done withheld; third frame stalls until done
        ack_delay = -1;
        p0 = pulses[1];
        send_rand(32, 1'b1);
        idle(1);
        chk("stall_ready", 32'(rdy[1]), 32'd0);
        chk("stall_busy", 32'(bsy[1]), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 16'h1234, 16'h5678, 1'b0, acc);
        ack_delay = 3;
        send_rand(16, 1'b1);
        idle(40);
        chk("b2b_pulses", 32'(pulses[1] - p0), 32'd3);
        chk("b2b_drained", 32'(frames.size()), 32'd0);

        // Restart at bin 7: only the restarted frame is presented
        ack_delay = 2;
        p0 = pulses[1];
        send_rand(7, 1'b1);
        send_rand(16, 1'b1);
        idle(10);
        chk("restart_pulses", 32'(pulses[1] - p0), 32'd1);

        // Reset while waiting for done, then mid-frame
        ack_delay = -1;
        send_rand(16, 1'b1);
        idle(3);
        chk("wait_presented", 32'(presented), 32'd1);
        do_reset();
        send_rand(8, 1'b1);
        do_reset();
        ack_delay = 2;
        p0 = pulses[1];
        send_rand(15, 1'b0);
        idle(5);
        chk("no_pulse_15_bins", 32'(pulses[1] - p0), 32'd0);
        send_rand(1, 1'b0);
        idle(6);
        chk("pulse_16_bins", 32'(pulses[1] - p0), 32'd1);

        // Random traffic: gaps, occasional restarts, varying done delay
        for (int r = 0; r < 6; r++) begin
            ack_delay = $urandom_range(0, 20);
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                send_bin($urandom_range(0, 19) == 0, 16'($urandom), 16'($urandom));
            end
        end

        // Drain everything outstanding
        ack_delay = 1;
        n = 0;
        while ((frames.size() != 0 || presented) && n < 500) begin
            idle(1);
            n++;
        end
        chk("drain_frames", 32'(frames.size()), 32'd0);
        for (int b = 0; b < 2; b++) begin
            chk($sformatf("total_pulses%0d", b), 32'(pulses[b]), 32'(acks + disc_presented));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_frame_tx.md
FFT_FRAME_TX -- requirements
Module: fft_frame_tx

Interface
REQ-001 Parameter BITREV, default 1, meaning incoming bin k is stored at slot bitrev4(k); 0 means slot k.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 bin_valid  input  1  serial bin present this cycle.
REQ-005 bin_first  input  1  qualifies bin_valid; marks bin 0 of a frame.
REQ-006 bin_real  input  16  signed real part of bin.
REQ-007 bin_imag  input  16  signed imaginary part of bin.
REQ-008 bin_ready  output  1  block can accept a bin this cycle.
REQ-009 fft_valid  output  1  one-cycle pulse: a complete 16-bin frame is on fft_d0..fft_d15.
REQ-010 fft_d0 .. fft_d15  output  32 each  frame slot N = {real[31:16], imag[15:0]}.
REQ-011 done  input  1  analyzer finished the presented frame (single-cycle pulse).
REQ-012 busy  output  1  high when either bank holds an unconsumed frame.

Function
REQ-013 The block shall hold two 16x32 banks (ping-pong), a write-bank pointer, a read-bank pointer, a 4-bit write counter and one full flag per bank.
REQ-014 Transfer shall occur on a rising edge where bin_valid and bin_ready are both 1; bin_ready shall equal NOT full[wr_bank], combinationally.
REQ-015 On transfer, {bin_real, bin_imag} shall be written to slot (BITREV ? bitrev4(cnt) : cnt) of wr_bank, then cnt increments, wrapping 15->0.
REQ-016 A transfer with bin_first=1 shall restart the frame: data written to slot 0, cnt becomes 1, previously written partial data in that bank is discarded (overwritten later).
REQ-017 The transfer with cnt=15 (and bin_first=0) shall set full[wr_bank], toggle wr_bank, and reset cnt to 0 at the same edge.
REQ-018 Reader FSM states: TX_IDLE, TX_SEND, TX_WAIT.
- TX_IDLE -> TX_SEND when full[rd_bank]=1.
- TX_SEND: fft_valid=1 for exactly this one cycle; -> TX_WAIT unconditionally.
- TX_WAIT -> TX_IDLE on done=1; at that edge clear full[rd_bank] and toggle rd_bank.
REQ-019 fft_valid shall be 0 in TX_IDLE and TX_WAIT; done shall be ignored outside TX_WAIT.
REQ-020 fft_d0..fft_d15 shall be driven from bank rd_bank and remain stable from the TX_SEND cycle until the edge that accepts done.
REQ-021 Latency: 16th bin accepted at edge k with reader idle -> fft_valid high between edges k+1 and k+2.
REQ-022 Next fft_valid may occur no earlier than the cycle after the TX_WAIT->TX_IDLE edge plus one (IDLE->SEND).
REQ-023 Setting full on one bank and clearing full on the other in the same edge shall both take effect; the writer never targets a full bank, so set/clear of the same bank cannot collide.
REQ-024 With both banks full, bin_ready=0 and inputs are not stored; no bin shall be dropped or overwritten.
REQ-025 busy = full[0] OR full[1].
REQ-026 Data is passed through unmodified; no arithmetic, saturation or sign change.

Reset
REQ-027 On rst=0 (asynchronous, any cycle, including mid-frame or in TX_WAIT): FSM=TX_IDLE, cnt=0, wr_bank=0, rd_bank=0, full=2'b00, fft_valid=0, busy=0, bin_ready=1 on release.
REQ-028 Bank contents need not be reset; fft_d0..fft_d15 are don't-care until the first fft_valid.
REQ-029 A partial frame or unacknowledged frame at reset is discarded; no fft_valid shall follow release without 16 new bins.

Verification
REQ-030 BITREV=1, 16 bins with real=k, imag=-k (k=0..15), first on k=0, done 15 cycles after fft_valid -> one fft_valid pulse, fft_d8=0x0001FFFF, fft_d1=0x0008FFF8, fft_d15=0x000FFFF1.
REQ-031 BITREV=0, same stimulus -> fft_dN = {N, -N}; fft_valid exactly 2 edges after 16th bin edge; stable until done.
REQ-032 Three frames back-to-back, done withheld -> bin_ready drops after 32nd bin, busy=1; on done, bin_ready=1 next cycle, 2nd frame fft_valid follows, no data lost.
REQ-033 bin_first asserted at bin 7 of a frame, then 15 more bins -> only one fft_valid, contents are the restarted frame.
REQ-034 rst pulsed low in TX_WAIT and mid-frame -> fft_valid=0, busy=0, bin_ready=1; next fft_valid only after 16 fresh bins.
REQ-035 done pulsed in TX_IDLE and in the TX_SEND cycle -> ignored; rd_bank and full unchanged.
